// File: rtl/decode_queue_pkg.sv
// Shared constants and FSM state type for the instruction decode byte queue.
package decode_queue_pkg;
  localparam int QUEUE_BYTES_DEFAULT  = 32;
  localparam int WINDOW_BYTES_DEFAULT = 16;
  localparam int FETCH_BYTES          = 4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_t;
endpackage

// File: rtl/decode_queue_ring.sv
// Byte ring storage: one fetch-word write port at the tail and a rotated
// multi-byte read port starting at the head. Contents are not reset.
module decode_queue_ring
  import decode_queue_pkg::*;
#(
  parameter int QUEUE_BYTES  = QUEUE_BYTES_DEFAULT,
  parameter int WINDOW_BYTES = WINDOW_BYTES_DEFAULT,
  localparam int PTR_W       = $clog2(QUEUE_BYTES)
) (
  input  logic                           clk,
  input  logic                           wr_en,
  input  logic [PTR_W-1:0]               wr_ptr,
  input  logic [FETCH_BYTES*8-1:0]       wr_data,
  input  logic [PTR_W-1:0]               rd_ptr,
  output logic [WINDOW_BYTES-1:0][7:0]   rd_data
);

  logic [7:0]       mem_q  [QUEUE_BYTES];
  logic [PTR_W-1:0] wr_idx [FETCH_BYTES];
  logic [PTR_W-1:0] rd_idx [WINDOW_BYTES];

  // Pointer arithmetic is PTR_W wide so every index wraps modulo QUEUE_BYTES.
  always_comb begin
    for (int k = 0; k < FETCH_BYTES; k++) wr_idx[k] = wr_ptr + PTR_W'(k);
    for (int i = 0; i < WINDOW_BYTES; i++) rd_idx[i] = rd_ptr + PTR_W'(i);
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < FETCH_BYTES; k++) mem_q[wr_idx[k]] <= wr_data[8*k +: 8];
    end
  end

  always_comb begin
    for (int i = 0; i < WINDOW_BYTES; i++) rd_data[i] = mem_q[rd_idx[i]];
  end

endmodule

// File: rtl/decode_queue_ctrl.sv
// Decode byte queue controller: RUN/FLUSH FSM, head/tail/count bookkeeping,
// fetch and consume handshakes, and a count-masked decode window.
module decode_queue_ctrl
  import decode_queue_pkg::*;
#(
  parameter int QUEUE_BYTES  = QUEUE_BYTES_DEFAULT,
  parameter int WINDOW_BYTES = WINDOW_BYTES_DEFAULT,
  localparam int PTR_W       = $clog2(QUEUE_BYTES),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         fetch_valid,
  input  logic [31:0]                  fetch_data,
  output logic                         fetch_ready,
  output logic [WINDOW_BYTES-1:0][7:0] window,
  output logic                         window_valid,
  output logic [CNT_W-1:0]             bytes_available,
  input  logic                         consume_valid,
  input  logic [3:0]                   consume_length,
  output logic                         consume_error
);

  state_t           state_q, state_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  logic             in_run;
  logic             push;
  logic             consume_ok;
  logic [CNT_W-1:0] len_ext;
  logic [WINDOW_BYTES-1:0][7:0] ring_rd;

  always_comb begin
    in_run      = (state_q == RUN);
    len_ext     = CNT_W'(consume_length);
    // Space check uses the pre-consume count so ready never depends on decode.
    fetch_ready = in_run && !flush && (count_q <= CNT_W'(QUEUE_BYTES - FETCH_BYTES));
    push        = fetch_valid && fetch_ready;
    consume_ok  = consume_valid && in_run && !flush &&
                  (consume_length != 4'd0) && (len_ext <= count_q);

    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    err_d   = 1'b0;

    if (flush) begin
      state_d = FLUSH;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      state_d = RUN;
      if (push)       tail_d = tail_q + PTR_W'(FETCH_BYTES);
      if (consume_ok) head_d = head_q + PTR_W'(consume_length);
      count_d = count_q + (push ? CNT_W'(FETCH_BYTES) : '0) - (consume_ok ? len_ext : '0);
      err_d   = consume_valid && !consume_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  decode_queue_ring #(
    .QUEUE_BYTES  (QUEUE_BYTES),
    .WINDOW_BYTES (WINDOW_BYTES)
  ) u_ring (
    .clk     (clk),
    .wr_en   (push),
    .wr_ptr  (tail_q),
    .wr_data (fetch_data),
    .rd_ptr  (head_q),
    .rd_data (ring_rd)
  );

  // Bytes beyond the queued count are stale storage and read as zero.
  always_comb begin
    for (int i = 0; i < WINDOW_BYTES; i++) begin
      window[i] = (in_run && (CNT_W'(i) < count_q)) ? ring_rd[i] : 8'h00;
    end
    window_valid    = in_run && (count_q != '0);
    bytes_available = in_run ? count_q : '0;
    consume_error   = err_q;
  end

endmodule

// File: tb/tb_decode_queue_ctrl.sv
// Directed bench for decode_queue_ctrl: a vector table for the steady flow and
// hand-written sequences for fill, wrap, error and flush corners.
module tb_decode_queue_ctrl;

  logic             clk = 1'b0;
  logic             rst, flush, fetch_valid, consume_valid;
  logic [31:0]      fetch_data;
  logic [3:0]       consume_length;
  logic             fetch_ready, window_valid, consume_error;
  logic [15:0][7:0] window;
  logic [5:0]       bytes_available;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  decode_queue_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .fetch_valid     (fetch_valid),
    .fetch_data      (fetch_data),
    .fetch_ready     (fetch_ready),
    .window          (window),
    .window_valid    (window_valid),
    .bytes_available (bytes_available),
    .consume_valid   (consume_valid),
    .consume_length  (consume_length),
    .consume_error   (consume_error)
  );

  typedef struct {
    logic        fl;
    logic        fv;
    logic [31:0] fd;
    logic        cv;
    logic [3:0]  cl;
    int          cnt;
    logic        rdy;
    logic        err;
    logic        vld;
    logic [7:0]  w0;
  } vec_t;

  vec_t tbl [12];

  // Word n carries stream bytes 4n-3..4n, so byte value = stream position + 1.
  function automatic logic [31:0] word(input int n);
    logic [7:0] b;
    b = 8'(4 * (n - 1) + 1);
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; fetch_valid = 0; fetch_data = '0; consume_valid = 0; consume_length = '0;
  endtask

  task automatic cyc(input logic fl, input logic fv, input logic [31:0] fd,
                     input logic cv, input logic [3:0] cl);
    flush = fl; fetch_valid = fv; fetch_data = fd; consume_valid = cv; consume_length = cl;
    @(posedge clk); #1;
    idle(); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 1;
    @(posedge clk); #1;
    rst = 0; #1;
  endtask

  task automatic put(input vec_t v, input logic fl, input logic fv, input logic [31:0] fd,
                     input logic cv, input logic [3:0] cl, input int cnt, input logic rdy,
                     input logic err, input logic vld, input logic [7:0] w0, output vec_t o);
    o = v;
    o.fl = fl; o.fv = fv; o.fd = fd; o.cv = cv; o.cl = cl;
    o.cnt = cnt; o.rdy = rdy; o.err = err; o.vld = vld; o.w0 = w0;
  endtask

  initial begin
    vec_t t;
    t = '{default: '0};
    //            fl fv fd        cv cl  cnt rdy err vld w0
    put(t, 0, 1, word(1), 0, 0,  4, 1, 0, 1, 8'h01, tbl[0]);
    put(t, 0, 1, word(2), 0, 0,  8, 1, 0, 1, 8'h01, tbl[1]);
    put(t, 0, 0, '0,      1, 3,  5, 1, 0, 1, 8'h04, tbl[2]);
    put(t, 0, 1, word(3), 1, 5,  4, 1, 0, 1, 8'h09, tbl[3]);
    put(t, 0, 0, '0,      1, 4,  0, 1, 0, 0, 8'h00, tbl[4]);
    put(t, 0, 0, '0,      1, 1,  0, 1, 1, 0, 8'h00, tbl[5]);
    put(t, 0, 0, '0,      0, 0,  0, 1, 0, 0, 8'h00, tbl[6]);
    put(t, 0, 1, word(4), 1, 2,  4, 1, 1, 1, 8'h0d, tbl[7]);
    put(t, 0, 0, '0,      1, 0,  4, 1, 1, 1, 8'h0d, tbl[8]);
    put(t, 1, 1, word(5), 1, 1,  0, 0, 0, 0, 8'h00, tbl[9]);
    put(t, 0, 0, '0,      0, 0,  0, 1, 0, 0, 8'h00, tbl[10]);
    put(t, 0, 1, word(5), 0, 0,  4, 1, 0, 1, 8'h11, tbl[11]);

    idle(); rst = 1;
    repeat (2) @(posedge clk);
    #1; rst = 0; #1;

    chk("reset_count", 32'(bytes_available), 0);
    chk("reset_ready", 32'(fetch_ready), 1);
    chk("reset_wvalid", 32'(window_valid), 0);
    chk("reset_err", 32'(consume_error), 0);
    chk("reset_window_lo", window[7:0], 0);
    chk("reset_window_hi", window[15:8], 0);

    for (int r = 0; r < 12; r++) begin
      cyc(tbl[r].fl, tbl[r].fv, tbl[r].fd, tbl[r].cv, tbl[r].cl);
      chk($sformatf("tbl%0d_count", r), 32'(bytes_available), 32'(tbl[r].cnt));
      chk($sformatf("tbl%0d_ready", r), 32'(fetch_ready), 32'(tbl[r].rdy));
      chk($sformatf("tbl%0d_err", r), 32'(consume_error), 32'(tbl[r].err));
      chk($sformatf("tbl%0d_wvalid", r), 32'(window_valid), 32'(tbl[r].vld));
      chk($sformatf("tbl%0d_w0", r), 32'(window[0]), 32'(tbl[r].w0));
    end

    // Two words in: eight ordered bytes, zero-masked tail of the window.
    do_reset();
    cyc(0, 1, word(1), 0, 0);
    cyc(0, 1, word(2), 0, 0);
    chk("two_words_count", 32'(bytes_available), 8);
    chk("two_words_wvalid", 32'(window_valid), 1);
    for (int i = 0; i < 16; i++)
      chk($sformatf("two_words_w%0d", i), 32'(window[i]), (i < 8) ? 32'(i + 1) : 0);

    // Fill boundary: push + consume at 28, blocked at 29, reopen after consume, then full.
    do_reset();
    for (int n = 1; n <= 7; n++) cyc(0, 1, word(n), 0, 0);
    chk("fill28_count", 32'(bytes_available), 28);
    chk("fill28_ready", 32'(fetch_ready), 1);
    cyc(0, 1, word(8), 1, 3);
    chk("push_consume_count", 32'(bytes_available), 29);
    chk("push_consume_w0", 32'(window[0]), 32'h04);
    chk("cnt29_ready", 32'(fetch_ready), 0);
    cyc(0, 1, word(9), 0, 0);
    chk("cnt29_push_count", 32'(bytes_available), 29);
    cyc(0, 0, '0, 1, 5);
    chk("consume5_count", 32'(bytes_available), 24);
    chk("consume5_ready", 32'(fetch_ready), 1);
    chk("consume5_w0", 32'(window[0]), 32'h09);
    cyc(0, 1, word(9), 0, 0);
    cyc(0, 1, word(10), 0, 0);
    chk("full_count", 32'(bytes_available), 32);
    chk("full_ready", 32'(fetch_ready), 0);
    chk("full_w15", 32'(window[15]), 32'h18);

    // Rejected consumes: too long, then zero length; error lasts one cycle.
    do_reset();
    cyc(0, 1, word(1), 0, 0);
    cyc(0, 0, '0, 1, 2);
    chk("cnt2_count", 32'(bytes_available), 2);
    cyc(0, 0, '0, 1, 3);
    chk("overlen_err", 32'(consume_error), 1);
    chk("overlen_count", 32'(bytes_available), 2);
    chk("overlen_w0", 32'(window[0]), 32'h03);
    cyc(0, 0, '0, 0, 0);
    chk("err_one_cycle", 32'(consume_error), 0);
    cyc(0, 0, '0, 1, 0);
    chk("zerolen_err", 32'(consume_error), 1);
    chk("zerolen_count", 32'(bytes_available), 2);

    // Window straddling the end of the ring: head=30, bytes 0x1f..0x28 queued.
    do_reset();
    for (int n = 1; n <= 8; n++) cyc(0, 1, word(n), 0, 0);
    cyc(0, 0, '0, 1, 15);
    cyc(0, 0, '0, 1, 15);
    chk("head30_count", 32'(bytes_available), 2);
    cyc(0, 1, word(9), 0, 0);
    cyc(0, 1, word(10), 0, 0);
    chk("wrap_count", 32'(bytes_available), 10);
    for (int i = 0; i < 16; i++)
      chk($sformatf("wrap_w%0d", i), 32'(window[i]), (i < 10) ? 32'(8'h1f + i) : 0);

    // Flush beats push and consume; held flush stays in FLUSH one more cycle.
    do_reset();
    cyc(0, 1, word(1), 0, 0);
    cyc(0, 1, word(2), 0, 0);
    cyc(1, 1, word(3), 1, 1);
    chk("flush_count", 32'(bytes_available), 0);
    chk("flush_ready", 32'(fetch_ready), 0);
    chk("flush_err", 32'(consume_error), 0);
    chk("flush_wvalid", 32'(window_valid), 0);
    cyc(1, 0, '0, 0, 0);
    chk("flush_held_ready", 32'(fetch_ready), 0);
    cyc(0, 1, word(4), 0, 0);
    chk("flush_drop_count", 32'(bytes_available), 0);
    chk("flush_exit_ready", 32'(fetch_ready), 1);
    cyc(0, 1, word(1), 0, 0);
    chk("post_flush_w0", 32'(window[0]), 32'h01);
    chk("post_flush_w4", 32'(window[4]), 32'h00);

    // Reset wins over concurrent push, consume and flush.
    cyc(0, 1, word(2), 0, 0);
    rst = 1; flush = 1; fetch_valid = 1; fetch_data = word(3); consume_valid = 1; consume_length = 4'd1;
    @(posedge clk); #1;
    rst = 0; idle(); #1;
    chk("midreset_count", 32'(bytes_available), 0);
    chk("midreset_ready", 32'(fetch_ready), 1);
    chk("midreset_err", 32'(consume_error), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_queue_ctrl.md
DECODE_QUEUE_CTRL -- requirements
Module: decode_queue_ctrl

Interface
REQ-001 SHALL have parameter QUEUE_BYTES, default 32, meaning ring-buffer depth in bytes (power of two, at least 32).
REQ-002 SHALL have parameter WINDOW_BYTES, default 16, meaning the byte count presented to the decode unit.
REQ-003 SHALL use one clock and a synchronous active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 flush  input  1  discard all queued bytes (control transfer).
REQ-007 fetch_valid  input  1  bus unit offers one fetch word.
REQ-008 fetch_data  input  32  fetch word; byte 0 = bits [7:0] = lowest address.
REQ-009 fetch_ready  output  1  queue accepts the offered word this cycle.
REQ-010 window  output  8x[0:15]  next 16 instruction bytes, in decode byte order.
REQ-011 window_valid  output  1  at least one byte is queued.
REQ-012 bytes_available  output  6  queued byte count, 0..QUEUE_BYTES.
REQ-013 consume_valid  input  1  decode retires an instruction of consume_length bytes.
REQ-014 consume_length  input  4  instruction length, legal range 1..15.
REQ-015 consume_error  output  1  one-cycle pulse when a consume request is rejected.

Function
REQ-016 States SHALL be RUN and FLUSH; reset enters RUN.
REQ-017 RUN SHALL go to FLUSH when flush=1 and SHALL otherwise stay in RUN.
REQ-018 FLUSH SHALL return to RUN after exactly one cycle, or stay in FLUSH if flush=1 again.
REQ-019 In RUN, fetch_ready SHALL be 1 iff count <= QUEUE_BYTES-4, evaluated on the pre-consume count.
REQ-020 In FLUSH or while flush=1, fetch_ready SHALL be 0 and any offered word SHALL be dropped.
REQ-021 A push (fetch_valid and fetch_ready) SHALL write 4 bytes at the tail and advance the tail by 4 modulo QUEUE_BYTES.
REQ-022 A consume SHALL be accepted iff state=RUN, flush=0, consume_length != 0 and consume_length <= count.
REQ-023 An accepted consume SHALL advance the head by consume_length modulo QUEUE_BYTES.
REQ-024 A rejected consume_valid SHALL pulse consume_error for one cycle and leave the head and count unchanged.
REQ-025 A simultaneous push and consume SHALL give count_next = count + 4 - consume_length in the same cycle.
REQ-026 flush SHALL take priority over push and consume: next cycle head=tail=0, count=0 and consume_error=0.
REQ-027 window[i] SHALL equal buf[(head+i) mod QUEUE_BYTES] for i < count, and 8'h00 for i >= count.
REQ-028 window SHALL be combinational from the registered head, count and buffer, so a pushed byte is visible the cycle after the push.
REQ-029 window_valid SHALL equal (count != 0) and bytes_available SHALL equal count; both are 0 in FLUSH.
REQ-030 Head and tail wrap-around SHALL be transparent: a window straddling index QUEUE_BYTES-1 to 0 is contiguous.
REQ-031 count SHALL never exceed QUEUE_BYTES or underflow; it SHALL hold 0..QUEUE_BYTES.

Reset
REQ-032 Reset SHALL set state=RUN, head=tail=count=0, fetch_ready=1, window_valid=0, bytes_available=0, consume_error=0 and window to all 8'h00.
REQ-033 Buffer storage contents SHALL need no reset; masking per REQ-027 hides them.
REQ-034 Reset asserted mid-operation SHALL override flush, push and consume in that cycle.

Structure
REQ-035 Package decode_queue_pkg SHALL hold QUEUE_BYTES_DEFAULT, WINDOW_BYTES_DEFAULT, FETCH_BYTES=4 and the enum state_t {RUN, FLUSH}.
REQ-036 The byte ring storage SHALL be one sub-module, decode_queue_ring: one 4-byte write port and a 16-byte rotated read port.
REQ-037 The FSM, pointers, count and handshake logic SHALL reside in decode_queue_ctrl.

Verification
REQ-038 Reset, then push 0x04030201 and 0x08070605 -> bytes_available=8, window[0:7]=01..08, window[8:15]=00, window_valid=1.
REQ-039 count=28, fetch_valid plus consume_length=3 in the same cycle -> push accepted, count=29.
REQ-040 count=29, push only -> fetch_ready=0 and no change; then consume 5 -> fetch_ready=1 next cycle.
REQ-041 count=2 and consume_length=3 -> consume_error pulses for one cycle and count stays 2; consume_length=0 -> consume_error.
REQ-042 head=30 with 8 bytes queued -> window[0:7] reads buf[30], buf[31], buf[0..5] in order.
REQ-043 flush together with fetch_valid and consume_valid -> next cycle count=0, fetch_ready=0 (FLUSH); the cycle after, RUN and fetch_ready=1.
